// File: rtl/rasterizer_pkg.sv
// Shared types, widths and helpers for triangle setup.
// Vertex/edge records and the setup FSM encoding.
package rasterizer_pkg;

   localparam int EDGE_AB_W = 17;
   localparam int EDGE_C_W  = 33;
   localparam int AREA_W    = 35;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic [31:0]        z;
      logic [31:0]        color;
   } vertex_t;

   typedef struct packed {
      logic signed [EDGE_AB_W-1:0] a;
      logic signed [EDGE_AB_W-1:0] b;
      logic signed [EDGE_C_W-1:0]  c;
   } edge_t;

   typedef enum logic [2:0] {
      COLLECT,
      EDGE0,
      EDGE1,
      EDGE2,
      AREA,
      OUT
   } setup_state_t;

   // Clamp a signed screen coordinate into [0, hi].
   function automatic logic [15:0] clamp_coord(input logic signed [15:0] v, input int hi);
      if (v < 0)
         return '0;
      else if (int'(v) > hi)
         return 16'(hi);
      else
         return v;
   endfunction

   function automatic logic signed [AREA_W-1:0] sext_c(input logic signed [EDGE_C_W-1:0] c);
      return {{(AREA_W-EDGE_C_W){c[EDGE_C_W-1]}}, c};
   endfunction

endpackage

// File: rtl/rasterizer_vertex_fifo.sv
// Synchronous vertex FIFO; head visible combinationally, pushes while full are dropped.
// count_nxt exposes the post-update occupancy so the caller can register a ready flag from it.
module rasterizer_vertex_fifo
   import rasterizer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  vertex_t                push_dat,
   input  logic                   pop,
   output vertex_t                pop_dat,
   output logic [$clog2(DEPTH):0] count,
   output logic [$clog2(DEPTH):0] count_nxt,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   vertex_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + CW'(1);
      else if (!do_push && do_pop)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/rasterizer_triangle_setup.sv
// Triangle setup: groups vertices into triangles, computes edge equations, area and clamped bbox.
// Third pop to tri_valid is 5 cycles; outputs hold while tri_ready is low, vertices keep buffering.
module rasterizer_triangle_setup
   import rasterizer_pkg::*;
#(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        vertex_valid,
   input  logic [3:0][31:0]            vertex_in,
   output logic                        vertex_ready,
   output logic                        tri_valid,
   input  logic                        tri_ready,
   output logic [2:0][EDGE_AB_W-1:0]   tri_edge_a,
   output logic [2:0][EDGE_AB_W-1:0]   tri_edge_b,
   output logic [2:0][EDGE_C_W-1:0]    tri_edge_c,
   output logic [AREA_W-1:0]           tri_area2,
   output logic [15:0]                 tri_bbox_min_x,
   output logic [15:0]                 tri_bbox_max_x,
   output logic [15:0]                 tri_bbox_min_y,
   output logic [15:0]                 tri_bbox_max_y,
   output logic [2:0][31:0]            tri_z,
   output logic [2:0][31:0]            tri_color,
   output logic                        overflow_err,
   output logic [15:0]                 culled_count
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   setup_state_t       state;
   setup_state_t       state_nxt;
   logic [1:0]         idx;
   vertex_t [2:0]      slot;
   edge_t [2:0]        edges;
   vertex_t            vtx_in;
   vertex_t            fifo_head;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   fifo_count_nxt;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic               unused_hi;

   always_comb begin
      vtx_in.x     = $signed(vertex_in[0][15:0]);
      vtx_in.y     = $signed(vertex_in[1][15:0]);
      vtx_in.z     = vertex_in[2];
      vtx_in.color = vertex_in[3];
   end
   assign unused_hi = ^{vertex_in[0][31:16], vertex_in[1][31:16]};

   assign fifo_pop = (state == COLLECT) && !fifo_empty;

   rasterizer_vertex_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (vertex_valid),
      .push_dat  (vtx_in),
      .pop       (fifo_pop),
      .pop_dat   (fifo_head),
      .count     (fifo_count),
      .count_nxt (fifo_count_nxt),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // One multiplier pair serves all three edges; the state picks the vertex pair.
   logic [1:0]                  ei;
   vertex_t                     vi;
   vertex_t                     vj;
   logic signed [31:0]          prod_ij;
   logic signed [31:0]          prod_ji;
   logic signed [EDGE_AB_W-1:0] edge_a_new;
   logic signed [EDGE_AB_W-1:0] edge_b_new;
   logic signed [EDGE_C_W-1:0]  edge_c_new;

   always_comb begin
      ei = 2'd0;
      vi = slot[0];
      vj = slot[1];
      case (state)
         EDGE1: begin ei = 2'd1; vi = slot[1]; vj = slot[2]; end
         EDGE2: begin ei = 2'd2; vi = slot[2]; vj = slot[0]; end
         default: ;
      endcase
   end

   assign prod_ij    = $signed(vi.x) * $signed(vj.y);
   assign prod_ji    = $signed(vj.x) * $signed(vi.y);
   assign edge_a_new = $signed({vi.y[15], vi.y}) - $signed({vj.y[15], vj.y});
   assign edge_b_new = $signed({vj.x[15], vj.x}) - $signed({vi.x[15], vi.x});
   assign edge_c_new = $signed({prod_ij[31], prod_ij}) - $signed({prod_ji[31], prod_ji});

   logic signed [AREA_W-1:0] area_sum;
   logic signed [15:0]       min_x;
   logic signed [15:0]       max_x;
   logic signed [15:0]       min_y;
   logic signed [15:0]       max_y;
   logic                     cull;

   assign area_sum = sext_c(edges[0].c) + sext_c(edges[1].c) + sext_c(edges[2].c);

   always_comb begin
      min_x = slot[0].x;
      max_x = slot[0].x;
      min_y = slot[0].y;
      max_y = slot[0].y;
      for (int i = 1; i < 3; i++) begin
         if (slot[i].x < min_x) min_x = slot[i].x;
         if (slot[i].x > max_x) max_x = slot[i].x;
         if (slot[i].y < min_y) min_y = slot[i].y;
         if (slot[i].y > max_y) max_y = slot[i].y;
      end
   end

   assign cull = (area_sum == '0) ||
                 (max_x < 0) || (int'(min_x) >= SCREEN_W) ||
                 (max_y < 0) || (int'(min_y) >= SCREEN_H);

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (fifo_pop && idx == 2'd2) state_nxt = EDGE0;
         EDGE0:   state_nxt = EDGE1;
         EDGE1:   state_nxt = EDGE2;
         EDGE2:   state_nxt = AREA;
         AREA:    state_nxt = cull ? COLLECT : OUT;
         OUT:     if (tri_ready) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= COLLECT;
         idx            <= 2'd0;
         slot           <= '0;
         edges          <= '0;
         tri_area2      <= '0;
         tri_bbox_min_x <= '0;
         tri_bbox_max_x <= '0;
         tri_bbox_min_y <= '0;
         tri_bbox_max_y <= '0;
         overflow_err   <= 1'b0;
         culled_count   <= '0;
         vertex_ready   <= 1'b1;
      end else begin
         state        <= state_nxt;
         vertex_ready <= (fifo_count_nxt <= CNT_W'(FIFO_DEPTH - 2));
         if (vertex_valid && fifo_full) overflow_err <= 1'b1;
         if (fifo_pop) begin
            slot[idx] <= fifo_head;
            idx       <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         end
         case (state)
            EDGE0, EDGE1, EDGE2: begin
               edges[ei].a <= edge_a_new;
               edges[ei].b <= edge_b_new;
               edges[ei].c <= edge_c_new;
            end
            AREA: begin
               if (cull) begin
                  culled_count <= culled_count + 16'd1;
               end else begin
                  // Clockwise input: flip every sign so the interior tests positive.
                  if (area_sum < 0) begin
                     for (int i = 0; i < 3; i++) begin
                        edges[i].a <= -edges[i].a;
                        edges[i].b <= -edges[i].b;
                        edges[i].c <= -edges[i].c;
                     end
                     tri_area2 <= -area_sum;
                  end else begin
                     tri_area2 <= area_sum;
                  end
                  tri_bbox_min_x <= clamp_coord(min_x, SCREEN_W - 1);
                  tri_bbox_max_x <= clamp_coord(max_x, SCREEN_W - 1);
                  tri_bbox_min_y <= clamp_coord(min_y, SCREEN_H - 1);
                  tri_bbox_max_y <= clamp_coord(max_y, SCREEN_H - 1);
               end
            end
            default: ;
         endcase
      end
   end

   assign tri_valid = (state == OUT);

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         tri_edge_a[i] = edges[i].a;
         tri_edge_b[i] = edges[i].b;
         tri_edge_c[i] = edges[i].c;
         tri_z[i]      = slot[i].z;
         tri_color[i]  = slot[i].color;
      end
   end

endmodule
